// File: rtl/sfu_ctrl.sv
// rtl/sfu_ctrl.sv - op sequencer for the SFU accumulator column
//
// Drives the shared SFU op code so every lane loads (SET), accumulates (ACC)
// and optionally rectifies (RELU) num_acc psums per output vector, then holds
// the finished vector on the SFU output bus under a valid/ready handshake.
//
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-low reset
//   start            job launch pulse, sampled only while idle
//   num_acc          psums per output vector (0 behaves as 1), latched at start
//   num_out          output vectors per job (0 behaves as 1), latched at start
//   relu_en          apply RELU after the last accumulation, latched at start
//   psum_valid       upstream psum FIFO not empty
//   psum_rd          pop strobe to the upstream psum FIFO
//   sfu_op           op broadcast to all lanes: 00 NOP, 01 SET, 10 ACC, 11 RELU
//   out_valid        SFU output bus holds a finished vector
//   out_ready        downstream accepts the vector
//   busy             job in progress
//   done             one-cycle pulse after the last vector is accepted
module sfu_ctrl #(
  parameter int psum_bw = 16,
  parameter int cnt_bw  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [cnt_bw-1:0] num_acc,
  input  logic [cnt_bw-1:0] num_out,
  input  logic              relu_en,
  input  logic              psum_valid,
  output logic              psum_rd,
  output logic [1:0]        sfu_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  // psum_bw only documents the lane width this sequencer is paired with.
  if (psum_bw < 1) begin : g_psum_bw_unused
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ACC  = 3'd2,
    S_RELU = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_RELU = 2'b11;

  localparam logic [cnt_bw-1:0] CNT_ONE = {{(cnt_bw-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [cnt_bw-1:0] acc_cnt_q, acc_cnt_d;
  logic [cnt_bw-1:0] out_cnt_q, out_cnt_d;
  logic [cnt_bw-1:0] num_acc_q, num_acc_d;
  logic [cnt_bw-1:0] num_out_q, num_out_d;
  logic              relu_en_q, relu_en_d;

  logic [cnt_bw-1:0] acc_inc;
  state_e            after_last_acc;

  // Effective counts are stored, so 0 never reaches the comparators and the
  // largest count (all ones) is reached by acc_cnt without wrapping.
  assign acc_inc        = acc_cnt_q + CNT_ONE;
  assign after_last_acc = relu_en_q ? S_RELU : S_OUT;
  assign busy           = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      acc_cnt_q <= '0;
      out_cnt_q <= '0;
      num_acc_q <= '0;
      num_out_q <= '0;
      relu_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      out_cnt_q <= out_cnt_d;
      num_acc_q <= num_acc_d;
      num_out_q <= num_out_d;
      relu_en_q <= relu_en_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    out_cnt_d = out_cnt_q;
    num_acc_d = num_acc_q;
    num_out_d = num_out_q;
    relu_en_d = relu_en_q;
    psum_rd   = 1'b0;
    sfu_op    = OP_NOP;
    out_valid = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          num_acc_d = (num_acc == '0) ? CNT_ONE : num_acc;
          num_out_d = (num_out == '0) ? CNT_ONE : num_out;
          relu_en_d = relu_en;
          acc_cnt_d = '0;
          out_cnt_d = '0;
          state_d   = S_LOAD;
        end
      end

      S_LOAD: begin
        if (psum_valid) begin
          psum_rd   = 1'b1;
          sfu_op    = OP_SET;
          acc_cnt_d = CNT_ONE;
          state_d   = (num_acc_q > CNT_ONE) ? S_ACC : after_last_acc;
        end
      end

      S_ACC: begin
        // Without a psum the lanes see NOP and simply hold their partial sum.
        if (psum_valid) begin
          psum_rd   = 1'b1;
          sfu_op    = OP_ACC;
          acc_cnt_d = acc_inc;
          if (acc_inc == num_acc_q) begin
            state_d = after_last_acc;
          end
        end
      end

      S_RELU: begin
        sfu_op  = OP_RELU;
        state_d = S_OUT;
      end

      S_OUT: begin
        // NOP keeps the lane registers, and therefore the presented vector,
        // stable for as long as downstream back-pressures.
        out_valid = 1'b1;
        if (out_ready) begin
          if (out_cnt_q == num_out_q - CNT_ONE) begin
            state_d = S_DONE;
          end else begin
            out_cnt_d = out_cnt_q + CNT_ONE;
            state_d   = S_LOAD;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: doc/sfu_ctrl.md
# sfu_ctrl

Sequencer for the SFU accumulator column in the output path. Runs a job of one or more output vectors. For each vector it:
- pulls `num_acc` partial sums from the upstream psum FIFO;
- drives the shared SFU `OP` code for SET, ACC and an optional RELU;
- presents the finished vector to the downstream consumer with a valid/ready handshake.

It owns no arithmetic; it only decides which op every SFU lane executes each cycle.

## Interface
- `psum_bw`, 16: psum width. Not used for arithmetic; carried for instantiation consistency with the SFU lanes.
- `cnt_bw`, 8: width of the `num_acc` and `num_out` fields and their counters.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: job launch pulse. Sampled only in IDLE.
- `num_acc` input `cnt_bw`: psums accumulated per output vector. Latched at `start`; 0 is treated as 1.
- `num_out` input `cnt_bw`: output vectors per job. Latched at `start`; 0 is treated as 1.
- `relu_en` input 1: apply RELU after the last accumulation. Latched at `start`.
- `psum_valid` input 1: upstream FIFO holds a psum vector.
- `psum_rd` output 1: pop strobe to the upstream FIFO.
- `sfu_op` output 2: op broadcast to all SFU lanes. 00 NOP, 01 SET, 10 ACC, 11 RELU.
- `out_valid` output 1: the SFU `psum_out` bus holds a finished vector.
- `out_ready` input 1: downstream accepts the vector.
- `busy` output 1: job in progress (state ≠ IDLE).
- `done` output 1: one-cycle pulse after the last vector is accepted.

## Operation
States: IDLE, LOAD, ACC, RELU, OUT, DONE.

- **IDLE**
  - `sfu_op` = NOP.
  - `start` = 1 latches the fields, clears `acc_cnt` and `out_cnt`, then moves to LOAD.
- **LOAD**
  - If `psum_valid` = 1: `psum_rd` = 1, `sfu_op` = SET, `acc_cnt` ← 1.
    - Next state is ACC if `num_acc_eff` > 1.
    - Otherwise RELU if `relu_en`, else OUT.
  - If `psum_valid` = 0: `sfu_op` = NOP; stay in LOAD.
- **ACC**
  - If `psum_valid` = 1: `psum_rd` = 1, `sfu_op` = ACC, `acc_cnt` increments.
    - When the incremented count equals `num_acc_eff`, go to RELU if `relu_en`, else OUT.
  - If `psum_valid` = 0: `sfu_op` = NOP (stall, accumulator held); stay in ACC.
- **RELU**
  - `sfu_op` = RELU for exactly one cycle, then OUT.
- **OUT**
  - `sfu_op` = NOP, `out_valid` = 1.
  - The vector must stay stable while `out_ready` = 0, since NOP holds the SFU accumulators.
  - On `out_valid` && `out_ready`:
    - if `out_cnt` = `num_out_eff` − 1, go to DONE;
    - else increment `out_cnt` and go to LOAD.
- **DONE**
  - `done` = 1 and `sfu_op` = NOP for one cycle, then IDLE.

Rules:
- `sfu_op` and `psum_rd` are combinational from state and `psum_valid`.
- `psum_rd` is never asserted outside LOAD/ACC, and never without `psum_valid`.
- `start` while busy is ignored; latched fields do not change mid-job.
- Counters are `cnt_bw` wide; `num_acc` = 2^`cnt_bw` − 1 must complete without wrap.
- Reset low (any time, including mid-job) forces:
  - state = IDLE, counters = 0;
  - `sfu_op` = NOP, `psum_rd` = 0, `out_valid` = 0, `busy` = 0, `done` = 0.
  - A partial accumulation is abandoned; the next job starts with SET, so SFU contents are irrelevant.

## Timing
- The SFU registers on the edge after the op is issued. OUT is entered on that same edge, so `out_valid` is asserted only once `psum_out` already reflects the final op.
- Minimum cycles per vector with `psum_valid` held high and `out_ready` high:
  - `num_acc_eff` (LOAD/ACC) + 1 if `relu_en` + 1 (OUT).
- Job overhead: +1 for the IDLE→LOAD edge, +1 for DONE.
- `start` in cycle 0 puts LOAD in cycle 1, so the first `psum_rd` can occur in cycle 1.
- A stall in LOAD/ACC or in OUT adds exactly one cycle per stalled cycle; no ops are lost or duplicated.

## Test plan
- **Basic accumulate:** `num_acc` = 3, `num_out` = 1, `relu_en` = 0, `psum_valid` always 1.
  - Required: `sfu_op` sequence SET, ACC, ACC, NOP; exactly 3 `psum_rd`.
  - Required: `out_valid` in cycle 4 with SFU value = sum of the three psums (e.g. 5 + (−2) + 7 = 10); `done` in cycle 5 after `out_ready`.
- **RELU path:** `num_acc` = 2, `relu_en` = 1, psums −4, 1.
  - Required: ops SET, ACC, RELU; output 0.
  - Repeat with psums 4, 1: output 5.
- **Stalls:** `num_acc` = 4 with `psum_valid` low on alternate cycles, and `out_ready` low for 3 cycles in OUT.
  - Required: NOP on every stall cycle; exactly 4 `psum_rd`.
  - Required: `out_valid` held 4 cycles with a constant value.
- **Multi-vector job:** `num_out` = 3, `num_acc` = 2.
  - Required: three OUT handshakes, each preceded by a fresh SET; `done` only after the third accept; `busy` high throughout.
- **Edge fields:** `num_acc` = 0 behaves as 1 (single SET). `num_acc` = 255 gives 1 SET + 254 ACC with no counter wrap. `start` pulsed while busy is ignored.
- **Reset mid-job:** assert `reset` low during ACC.
  - Required: outputs immediately go to their reset values asynchronously.
  - Required: after release, a new job runs correctly starting with SET.
